// File: rtl/y86_seq_writeback.sv
// Y86-64 SEQ write-back stage: decodes the E/M destinations from icode/rA/rB/Cnd,
// owns the program register file and serves two combinational decode read ports.
module y86_seq_writeback #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [3:0]              in_code,
  input  logic [3:0]              ra,
  input  logic [3:0]              rb,
  input  logic                    cnd,
  input  logic [DATA_W-1:0]       val_e,
  input  logic [DATA_W-1:0]       val_m,
  input  logic [3:0]              src_a,
  input  logic [3:0]              src_b,
  output logic [DATA_W-1:0]       val_a,
  output logic [DATA_W-1:0]       val_b,
  output logic [3:0]              dst_e,
  output logic [3:0]              dst_m,
  output logic [DATA_W*NREGS-1:0] regs_flat
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  logic [DATA_W-1:0] regs [NREGS];

  always_comb begin
    dst_e = RNONE;
    case (in_code)
      4'h2:                      dst_e = cnd ? rb : RNONE;
      4'h3, 4'h6:                dst_e = rb;
      4'h8, 4'h9, 4'hA, 4'hB:    dst_e = RRSP;
      default:                   dst_e = RNONE;
    endcase
  end

  always_comb begin
    dst_m = RNONE;
    case (in_code)
      4'h5, 4'hB: dst_m = ra;
      default:    dst_m = RNONE;
    endcase
  end

  // Per-entry compare keeps ID 0xF harmless and makes the M-over-E priority explicit.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NREGS; i++) begin
      if (reset)
        regs[i] <= '0;
      else if (dst_m == 4'(i))
        regs[i] <= val_m;
      else if (dst_e == 4'(i))
        regs[i] <= val_e;
    end
  end

  // Reads see pre-edge contents; RNONE and any unmapped ID read as zero.
  always_comb begin
    val_a = '0;
    val_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (src_a == 4'(i)) val_a = regs[i];
      if (src_b == 4'(i)) val_b = regs[i];
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NREGS; i++)
      regs_flat[DATA_W*i +: DATA_W] = regs[i];
  end

endmodule

// File: tb/tb_y86_seq_writeback.sv
// Bench for y86_seq_writeback: directed scenarios then random instructions checked
// against an array model of the register file.
module tb_y86_seq_writeback;

  logic         clock;
  logic         reset;
  logic [3:0]   in_code, ra, rb;
  logic         cnd;
  logic [63:0]  val_e, val_m;
  logic [3:0]   src_a, src_b;
  logic [63:0]  val_a, val_b;
  logic [3:0]   dst_e, dst_m;
  logic [959:0] regs_flat;

  logic [63:0] model_r [15];
  int tests = 0;
  int fails = 0;

  y86_seq_writeback dut (
    .clock(clock), .reset(reset), .in_code(in_code), .ra(ra), .rb(rb), .cnd(cnd),
    .val_e(val_e), .val_m(val_m), .src_a(src_a), .src_b(src_b),
    .val_a(val_a), .val_b(val_b), .dst_e(dst_e), .dst_m(dst_m), .regs_flat(regs_flat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_dst_e(input logic [3:0] c, input logic [3:0] b, input logic f);
    if (c == 4'h2) return f ? b : 4'hF;
    if (c == 4'h3 || c == 4'h6) return b;
    if (c >= 4'h8 && c <= 4'hB) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] ref_dst_m(input logic [3:0] c, input logic [3:0] a);
    return (c == 4'h5 || c == 4'hB) ? a : 4'hF;
  endfunction

  function automatic logic [63:0] ref_read(input logic [3:0] s);
    return (s == 4'hF) ? 64'd0 : model_r[s];
  endfunction

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 15; i++)
      check($sformatf("%s_r%0d", tag, i), regs_flat[64*i +: 64], model_r[i]);
  endtask

  // One instruction: check decode and pre-edge reads, clock it, check post-edge state.
  task automatic run_step(input string tag, input logic rst, input logic [3:0] c,
                          input logic [3:0] a, input logic [3:0] b, input logic f,
                          input logic [63:0] ve, input logic [63:0] vm,
                          input logic [3:0] sa, input logic [3:0] sb);
    logic [3:0] de, dm;
    reset = rst; in_code = c; ra = a; rb = b; cnd = f;
    val_e = ve; val_m = vm; src_a = sa; src_b = sb;
    #1;
    de = ref_dst_e(c, b, f);
    dm = ref_dst_m(c, a);
    check({tag, "_dst_e"}, {60'd0, dst_e}, {60'd0, de});
    check({tag, "_dst_m"}, {60'd0, dst_m}, {60'd0, dm});
    check({tag, "_val_a_pre"}, val_a, ref_read(sa));
    check({tag, "_val_b_pre"}, val_b, ref_read(sb));
    @(posedge clock);
    if (rst) begin
      for (int i = 0; i < 15; i++) model_r[i] = 64'd0;
    end else begin
      if (de != 4'hF) model_r[de] = ve;
      if (dm != 4'hF) model_r[dm] = vm;
    end
    #1;
    check_all_regs(tag);
    check({tag, "_val_a_post"}, val_a, ref_read(sa));
    check({tag, "_val_b_post"}, val_b, ref_read(sb));
  endtask

  initial begin
    for (int i = 0; i < 15; i++) model_r[i] = 64'd0;
    reset = 1'b1; in_code = 4'h1; ra = 4'hF; rb = 4'hF; cnd = 1'b0;
    val_e = '0; val_m = '0; src_a = 4'hF; src_b = 4'h0;

    // Reset clears everything; RNONE reads zero.
    run_step("reset", 1'b1, 4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 4'hF, 4'h0);
    check("reset_flat_zero", {63'd0, regs_flat == '0}, 64'd1);

    // irmovq writes only R[rb].
    run_step("irmovq", 1'b0, 4'h3, 4'hF, 4'h2, 1'b0, 64'd21, 64'd58, 4'h2, 4'h3);
    // cmov not taken, then taken.
    run_step("cmov_nt", 1'b0, 4'h2, 4'h3, 4'h2, 1'b0, 64'd77, 64'd0, 4'h2, 4'h3);
    run_step("cmov_t", 1'b0, 4'h2, 4'h3, 4'h2, 1'b1, 64'd77, 64'd0, 4'h2, 4'h3);
    // rmmovq writes nothing.
    run_step("rmmovq", 1'b0, 4'h4, 4'h0, 4'h4, 1'b1, 64'd81, 64'd66, 4'h4, 4'h2);
    // popq: E to %rsp and M to rA; popq %rsp lets M win.
    run_step("popq", 1'b0, 4'hB, 4'h5, 4'hF, 1'b0, 64'd261, 64'd262, 4'h4, 4'h5);
    run_step("popq_rsp", 1'b0, 4'hB, 4'h4, 4'hF, 1'b0, 64'd8, 64'd9, 4'h4, 4'h5);
    // Reset overrides a pending mrmovq write; the retried write lands.
    run_step("mrmovq_rst", 1'b1, 4'h5, 4'h7, 4'hF, 1'b0, 64'd0, 64'd10, 4'h7, 4'h4);
    run_step("mrmovq", 1'b0, 4'h5, 4'h7, 4'hF, 1'b0, 64'd0, 64'd10, 4'h7, 4'h4);
    // Full-width values stored unmodified; destination 0xF is a no-op.
    run_step("opq_wide", 1'b0, 4'h6, 4'h1, 4'hE, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 4'hE, 4'hF);
    run_step("irmovq_rnone", 1'b0, 4'h3, 4'h1, 4'hF, 1'b1, 64'hDEAD_BEEF_0000_0001, 64'd3, 4'hE, 4'h0);

    for (int n = 0; n < 300; n++) begin
      run_step($sformatf("rnd%0d", n),
               ($urandom_range(0, 39) == 0),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               {$urandom, $urandom}, {$urandom, $urandom},
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
